// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared types and helpers for the UART data-path FIFO
//   fifo_mode_e : read mode selector (FIFO_REG registered, FIFO_FWFT show-ahead)
//   fifo_cw     : width of level/threshold buses for a given depth (0..DEPTH)
//   parity      : even-parity bit of up to 64 data bits (zero-extend narrower data)
package uart_fifo_pkg;

   typedef enum logic {FIFO_REG, FIFO_FWFT} fifo_mode_e;

   function automatic int fifo_cw(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic logic parity(input logic [63:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: DEPTH x W storage, one synchronous write port and one asynchronous read port
//   clk   in  clock
//   we    in  write enable
//   wa    in  write index
//   wd    in  write data
//   ra    in  read index
//   rd    out read data (combinational from ra)
module sync_fifo_ram #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int IW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [IW-1:0] wa,
   input  logic [W-1:0]  wd,
   input  logic [IW-1:0] ra,
   output logic [W-1:0]  rd
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk)
      if (we) mem[wa] <= wd;

   assign rd = mem[ra];

endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO, any depth, registered or FWFT read, programmable almost flags
//   clk, rst_n (async, active-low)      clock and reset
//   flush                               synchronous clear of indices and level
//   wr_en, wr_data                      push request and data
//   rd_en, rd_data                      pop request and read data
//   full, empty, almost_full, almost_empty, level   occupancy status
//   af_thresh, ae_thresh                almost-full / almost-empty thresholds
//   overflow, underflow, err_clr        sticky error flags and their clear
//   par_inject, parity_err              parity fault injection / detection
// Macro SYNC_FIFO_PARITY_EN adds a stored even-parity bit per entry; without it
// par_inject is ignored and parity_err is tied low.
module sync_fifo_prog
   import uart_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int FWFT       = 0,
   parameter int CW         = fifo_cw(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   input  logic [CW-1:0]         af_thresh,
   input  logic [CW-1:0]         ae_thresh,
   output logic [CW-1:0]         level,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr,
   input  logic                  par_inject,
   output logic                  parity_err
);

   localparam int IW = $clog2(DEPTH);
`ifdef SYNC_FIFO_PARITY_EN
   localparam int W = DATA_WIDTH + 1;
`else
   localparam int W = DATA_WIDTH;
`endif
   localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

   logic [IW-1:0] wr_idx, rd_idx;
   logic [CW-1:0] cnt;
   logic [W-1:0]  wd, q;
   logic          push, pop;

   assign full         = cnt == CW'(DEPTH);
   assign empty        = cnt == '0;
   assign almost_full  = cnt >= af_thresh;
   assign almost_empty = cnt <= ae_thresh;
   assign level        = cnt;

   // flush swallows every request of its cycle
   assign push = wr_en & ~full & ~flush;
   assign pop  = rd_en & ~empty & ~flush;

   sync_fifo_ram #(.W(W), .DEPTH(DEPTH), .IW(IW)) u_ram (
      .clk (clk),
      .we  (push),
      .wa  (wr_idx),
      .wd  (wd),
      .ra  (rd_idx),
      .rd  (q)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_idx    <= '0;
         rd_idx    <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (flush) begin
            wr_idx <= '0;
            rd_idx <= '0;
            cnt    <= '0;
         end else begin
            if (push) wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
            if (pop)  rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
            if (push != pop) cnt <= push ? cnt + 1'b1 : cnt - 1'b1;
         end
         // a new error outranks a simultaneous clear
         overflow  <= (wr_en & full & ~flush) | (overflow & ~err_clr);
         underflow <= (rd_en & empty & ~flush) | (underflow & ~err_clr);
      end

   generate
      if (FWFT == int'(FIFO_FWFT)) begin : g_fwft
         assign rd_data = empty ? '0 : q[DATA_WIDTH-1:0];
      end else begin : g_reg
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) rd_data <= '0;
            else if (pop) rd_data <= q[DATA_WIDTH-1:0];
      end
   endgenerate

`ifdef SYNC_FIFO_PARITY_EN
   logic pe;
   assign wd = {parity(64'(wr_data)) ^ par_inject, wr_data};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pe <= 1'b0;
      else pe <= pop & (parity(64'(q[DATA_WIDTH-1:0])) != q[DATA_WIDTH]);
   assign parity_err = pe;
`else
   logic unused_par;
   assign wd         = wr_data;
   assign unused_par = par_inject;
   assign parity_err = 1'b0;
`endif

endmodule
